seq_mul_arbiter: RTL and testbench
==================================

// Module: seq_mul_arbiter
// PURPOSE
//  Shares one seq_mul (16x16 sequential multiplier) among N_REQ requesters using round-robin arbitration.
//  Sequences the multiplier: latches operands, drives a 1-cycle write, waits MUL_LATENCY cycles, then
//  captures the product. Returns the product and the requester id on a valid/ready response port.
//  Sits between the requester-side fabric and the single seq_mul instance.
// PARAMETERS
//  N_REQ        4   number of requesters (>=2)
//  WIDTH        16  operand width; product is 2*WIDTH
//  MUL_LATENCY  17  cycles from the mul_write cycle to a valid mul_prod (>=1)
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-low reset
//  req_valid  in   N_REQ        per-requester request valid
//  req_a      in   N_REQ*WIDTH  packed multiplicands; requester i at [i*WIDTH +: WIDTH]
//  req_b      in   N_REQ*WIDTH  packed multipliers, same packing
//  req_ready  out  N_REQ        one-hot grant; accept = req_valid[i] & req_ready[i]
//  rsp_valid  out  1            response valid
//  rsp_ready  in   1            response consumer ready
//  rsp_id     out  clog2(N_REQ) index of the served requester
//  rsp_prod   out  2*WIDTH      product
//  busy       out  1            high in every state except IDLE
//  mul_write  out  1            to seq_mul write (load operands)
//  mul_a      out  WIDTH        to seq_mul multiplicand
//  mul_b      out  WIDTH        to seq_mul multiplier
//  mul_prod   in   2*WIDTH      from seq_mul product
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, wait counter=0. All outputs are 0.
//  FSM IDLE->LOAD->WAIT->RESP->IDLE.
//  - IDLE: if |req_valid, then grant = first set bit searching from rr_ptr upward (wraps).
//    req_ready[grant]=1 combinationally in the same cycle. On accept, register the operands and id,
//    then go to LOAD. No req_valid: stay in IDLE and keep req_ready=0.
//  - LOAD: mul_write=1 for exactly this one cycle. Load cnt=MUL_LATENCY-1. Go to WAIT.
//  - WAIT: decrement cnt. When cnt==0, register mul_prod into rsp_prod and go to RESP.
//  - RESP: hold rsp_valid=1 and keep rsp_id/rsp_prod stable until rsp_ready.
//    On handshake: rr_ptr = (rsp_id+1) mod N_REQ, then go to IDLE.
//  mul_a/mul_b are driven from the operand registers. They are stable from LOAD until the exit from WAIT.
//  req_ready=0 in every state except IDLE. At most one transaction is in flight.
//  Latency: accept in cycle T, mul_write in T+1, rsp_valid first high in T+2+MUL_LATENCY.
//  Minimum issue interval (rsp_ready held high) is MUL_LATENCY+3 cycles.
//  Width: operands are unsigned. rsp_prod is the full 2*WIDTH result with no truncation.
//  Example: 0xFFFF*0xFFFF=0xFFFE0001.
//  Boundaries:
//  - req_valid dropped before grant: legal, no transaction starts. Requesters hold operands while valid & !ready.
//  - All requesters valid: serve 0,1,2,3,0,... with no starvation.
//  - rr_ptr pointing at an idle requester: skip it and grant the next valid one.
//  - rsp_ready low: stall in RESP indefinitely. No new grant and no mul_write.
//  - rsp_ready high on the first RESP cycle: RESP lasts 1 cycle.
//  - Reset asserted mid-operation: immediate async return to reset values. The in-flight result is discarded.
//    The first grant after reset comes from rr_ptr=0.
// STRUCTURE
//  Shared package seq_mul_pkg: state encodings (IDLE/LOAD/WAIT/RESP), default WIDTH, and a clog2 function.
//  Sub-module rr_arbiter (N_REQ, inputs req/ptr, output one-hot grant plus index): purely combinational.
//  The FSM, counter, operand/result registers and rr_ptr all live in seq_mul_arbiter.
// TESTING  (bench instantiates seq_mul_arbiter + real seq_mul; clk period 10 ns)
//  1. Reset: hold reset=0 for 2 cycles -> all outputs 0 and busy=0. Pulse reset low mid-WAIT ->
//     busy=0 in the same cycle and no rsp_valid follows.
//  2. Single request: req0 a=17, b=16 -> mul_write high for exactly 1 cycle. rsp_valid rises at
//     T+2+MUL_LATENCY with rsp_id=0 and rsp_prod=272.
//  3. All four valid with a=i+1, b=100 -> responses in id order 0,1,2,3 with products 100,200,300,400.
//     Then 0 again.
//  4. Only req2 and req3 valid, ptr=3 -> req3 is served first, then req2.
//  5. Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id and rsp_prod are stable,
//     req_ready=0 and mul_write=0 throughout.
//  6. Extremes: 0xFFFF*0xFFFF -> 0xFFFE0001. 0*0x1234 -> 0. 1*0xFFFF -> 0x0000FFFF.

Source files
------------

// File: rtl/seq_mul_arbiter_pkg.sv
// seq_mul_arbiter_pkg: shared FSM encoding, default sizes and a width helper
package seq_mul_arbiter_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_MUL_LATENCY = 17;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

    // never returns 0 so that derived vectors always have at least one bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/seq_mul_arbiter_if.sv
// seq_mul_arbiter_if: requester-side request and response handshakes
interface seq_mul_arbiter_if
    import seq_mul_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) ();
    localparam int IW = clog2(N_REQ);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id;
    logic [2*WIDTH-1:0]     rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: unsigned shift-add multiplier; product valid WIDTH+1 cycles after the write cycle
module seq_mul
    import seq_mul_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_write,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod
);
    localparam int CW = clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] r_mcand, r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_mplier <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_write) begin
            r_mcand <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc <= '0;
            r_cnt <= CW'(WIDTH);
        end else if (r_cnt != '0) begin
            r_acc <= r_mplier[0] ? r_acc + r_mcand : r_acc;
            r_mcand <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_prod = r_acc;
endmodule

// File: rtl/seq_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter
    import seq_mul_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx
);
    // scan from the farthest offset down so the nearest request wins
    always_comb begin
        o_grant = '0;
        o_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[IW'((int'(i_ptr) + k) % N_REQ)]) o_idx = IW'((int'(i_ptr) + k) % N_REQ);
        end
        o_grant[o_idx] = |i_req;
    end
endmodule

// File: rtl/seq_mul_arbiter.sv
// seq_mul_arbiter: round-robin sharing of one seq_mul among N_REQ requesters,
// one transaction in flight: IDLE -> LOAD -> WAIT -> RESP -> IDLE
module seq_mul_arbiter
    import seq_mul_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_mul_arbiter_if.slave   bus,
    output logic               o_busy,
    output logic               o_mul_write,
    output logic [WIDTH-1:0]   o_mul_a,
    output logic [WIDTH-1:0]   o_mul_b,
    input  logic [2*WIDTH-1:0] i_mul_prod
);
    localparam int IW = clog2(N_REQ);
    localparam int CW = clog2(MUL_LATENCY + 1);

    state_t             r_state, w_next;
    logic [IW-1:0]      r_ptr, r_id, w_idx;
    logic [N_REQ-1:0]   w_grant;
    logic [WIDTH-1:0]   r_a, r_b, w_a, w_b;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               w_accept, w_done;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // grant is suppressed while reset is held so every output reads 0
    assign bus.req_ready = (r_state == S_IDLE && rst_n) ? w_grant : '0;
    assign w_accept = |(bus.req_valid & bus.req_ready);
    assign w_done = r_state == S_WAIT && r_cnt == '0;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == IW'(i)) begin
                w_a = bus.req_a[i*WIDTH +: WIDTH];
                w_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  w_next = w_done ? S_RESP : S_WAIT;
            S_RESP:  w_next = bus.rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_id <= '0;
            r_a <= '0;
            r_b <= '0;
            r_prod <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_id <= w_idx;
                r_a <= w_a;
                r_b <= w_b;
            end
            if (r_state == S_LOAD) r_cnt <= CW'(MUL_LATENCY - 1);
            else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (w_done) r_prod <= i_mul_prod;
            if (r_state == S_RESP && bus.rsp_ready) r_ptr <= (r_id == IW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
        end
    end

    assign bus.rsp_valid = r_state == S_RESP;
    assign bus.rsp_id = r_id;
    assign bus.rsp_prod = r_prod;
    assign o_busy = r_state != S_IDLE;
    assign o_mul_write = r_state == S_LOAD;
    assign o_mul_a = r_a;
    assign o_mul_b = r_b;
endmodule

// File: tb/tb_seq_mul_arbiter.sv
// tb_seq_mul_arbiter: table vectors, hand-written corner cases and a randomized
// run against a round-robin/arithmetic reference model
module tb_seq_mul_arbiter;
    import seq_mul_arbiter_pkg::*;
    localparam int N = 4;
    localparam int W = 16;
    localparam int L = 17;

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        int          stall;
        int          exp_id;
        logic [31:0] exp_prod;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic busy, mul_write;
    logic [W-1:0] mul_a, mul_b;
    logic [2*W-1:0] mul_prod;
    int total = 0;
    int bad = 0;
    int m_ptr;
    vec_t vecs[11];

    seq_mul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    seq_mul_arbiter #(.N_REQ(N), .WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_busy      (busy),
        .o_mul_write (mul_write),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .i_mul_prod  (mul_prod)
    );

    seq_mul #(.WIDTH(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_write (mul_write),
        .i_a     (mul_a),
        .i_b     (mul_b),
        .o_prod  (mul_prod)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // entered and left on a negedge with the DUT idle
    task automatic run_txn(input vec_t v);
        int lat, wr;
        logic moved;
        logic [31:0] hold_prod;
        logic [1:0] hold_id;
        bus.req_valid = v.valid;
        bus.req_a = v.a;
        bus.req_b = v.b;
        bus.rsp_ready = (v.stall == 0);
        #1;
        chk("grant", 64'(bus.req_ready), 64'(1) << v.exp_id);
        @(negedge clk);
        bus.req_valid[v.exp_id] = 1'b0;
        chk("load_a", 64'(mul_a), 64'(v.a[v.exp_id*16 +: 16]));
        chk("load_b", 64'(mul_b), 64'(v.b[v.exp_id*16 +: 16]));
        lat = 1;
        wr = 0;
        moved = 1'b0;
        while (!bus.rsp_valid && lat < 4 * L) begin
            wr += int'(mul_write);
            moved |= |bus.req_ready;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(L + 2));
        chk("mul_write_cycles", 64'(wr), 64'd1);
        chk("no_grant_busy", 64'(moved), 64'd0);
        chk("rsp_id", 64'(bus.rsp_id), 64'(v.exp_id));
        chk("rsp_prod", 64'(bus.rsp_prod), 64'(v.exp_prod));
        hold_id = bus.rsp_id;
        hold_prod = bus.rsp_prod;
        moved = 1'b0;
        repeat (v.stall) begin
            @(negedge clk);
            moved |= !bus.rsp_valid || bus.rsp_id !== hold_id || bus.rsp_prod !== hold_prod
                     || mul_write || |bus.req_ready;
        end
        if (v.stall > 0) chk("stall_hold", 64'(moved), 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("resp_one_cycle", 64'(bus.rsp_valid), 64'd0);
        chk("idle_after_resp", 64'(busy), 64'd0);
    endtask

    initial begin
        automatic logic [63:0] all_a = {16'd4, 16'd3, 16'd2, 16'd1};
        automatic logic [63:0] all_b = {4{16'd100}};
        automatic logic seen;
        automatic vec_t rv;
        vecs[0] = '{4'b1111, all_a, all_b, 0, 0, 32'd100};
        vecs[1] = '{4'b1111, all_a, all_b, 1, 1, 32'd200};
        vecs[2] = '{4'b1111, all_a, all_b, 0, 2, 32'd300};
        vecs[3] = '{4'b1111, all_a, all_b, 0, 3, 32'd400};
        vecs[4] = '{4'b1111, all_a, all_b, 0, 0, 32'd100};
        vecs[5] = '{4'b0001, {48'd0, 16'd17}, {48'd0, 16'd16}, 2, 0, 32'd272};
        vecs[6] = '{4'b0100, {16'd0, 16'hFFFF, 32'd0}, {16'd0, 16'hFFFF, 32'd0}, 0, 2, 32'hFFFE0001};
        vecs[7] = '{4'b1100, {16'd1, 16'd0, 32'd0}, {16'hFFFF, 16'h1234, 32'd0}, 0, 3, 32'h0000FFFF};
        vecs[8] = '{4'b1100, {16'd1, 16'd0, 32'd0}, {16'hFFFF, 16'h1234, 32'd0}, 0, 2, 32'd0};
        vecs[9] = '{4'b1111, {16'h00AB, 48'd7}, {16'h0100, 48'd9}, 10, 3, 32'h0000AB00};
        vecs[10] = '{4'b0010, {32'd0, 16'd3, 16'd0}, {32'd0, 16'd5, 16'd0}, 0, 1, 32'd15};

        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_write", 64'(mul_write), 64'd0);
        chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_prod}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // request withdrawn before the clock edge starts nothing
        bus.req_valid = 4'b0001;
        #1 chk("drop_grant", 64'(bus.req_ready), 64'd1);
        #1 bus.req_valid = '0;
        @(negedge clk);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_mul_write", 64'(mul_write), 64'd0);

        for (int i = 0; i < 11; i++) run_txn(vecs[i]);

        // pointer now 2; abort a transaction mid-WAIT
        bus.req_valid = 4'b1000;
        bus.req_a = {16'd5, 48'd0};
        bus.req_b = {16'd7, 48'd0};
        @(negedge clk);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        chk("midwait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_rsp", {bus.rsp_valid, bus.rsp_prod}, 64'd0);
        chk("async_rst_mul", {mul_write, mul_a, mul_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (L + 5) begin
            @(negedge clk);
            seen |= bus.rsp_valid | busy | mul_write;
        end
        chk("no_resp_after_rst", 64'(seen), 64'd0);
        run_txn('{4'b1111, all_a, all_b, 0, 0, 32'd100});
        m_ptr = 1;

        for (int i = 0; i < 40; i++) begin
            rv.valid = 4'($urandom_range(1, 15));
            rv.a = {$urandom, $urandom};
            rv.b = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) rv.a = '1;
            if ($urandom_range(0, 4) == 0) rv.b = '1;
            rv.stall = $urandom_range(0, 3);
            rv.exp_id = rr_pick(rv.valid, m_ptr);
            rv.exp_prod = 32'(rv.a[rv.exp_id*16 +: 16]) * 32'(rv.b[rv.exp_id*16 +: 16]);
            run_txn(rv);
            m_ptr = (rv.exp_id + 1) % N;
            if (i % 10 == 9) begin
                bus.req_valid = '0;
                repeat (3) @(negedge clk);
                chk("idle_gap_busy", 64'(busy), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
